// File: rtl/johnson_pkg.sv
// Shared types for Johnson-code consumers: decoder FSM states and the
// classification of one decoded index against the previous one.
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } jd_state_e;

    typedef enum logic [1:0] {
        HOLD,
        FWD,
        BWD,
        BAD
    } step_e;

    // Relation of idx to prev on a ring of 'states' positions, wrap included
    function automatic step_e classify_step(
        input int unsigned idx,
        input int unsigned prev,
        input int unsigned states
    );
        if (idx == prev) begin
            return HOLD;
        end
        if (idx == (prev + 1) % states) begin
            return FWD;
        end
        if (idx == (prev + states - 1) % states) begin
            return BWD;
        end
        return BAD;
    endfunction

endpackage

// File: rtl/johnson_word_decode.sv
// Combinational Johnson word decoder: checks the word shape and maps it to
// its position 0..2N-1 in the forward sequence.
module johnson_word_decode #(
    parameter  int N  = 4,
    localparam int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  i_code,
    output logic          o_legal,
    output logic [IW-1:0] o_idx
);

    int unsigned w_pop;
    int unsigned w_edges;

    // A Johnson word has at most one boundary between its run of ones and zeros
    always_comb begin
        w_pop   = 0;
        w_edges = 0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + 32'(i_code[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            if (i_code[i] != i_code[i+1]) begin
                w_edges = w_edges + 1;
            end
        end
        o_legal = (w_edges <= 1);
        if (i_code[0] || (w_pop == 0)) begin
            o_idx = IW'(w_pop);
        end else begin
            o_idx = IW'(32'(2 * N) - w_pop);
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson bus receiver: decodes each sampled word, tracks direction and
// lock through a SEARCH/ACQUIRE/LOCKED FSM, and counts code errors.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int MISS_MAX = 2,
    localparam int IW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  code_in,
    input  logic          code_valid,
    input  logic          err_clr,
    output logic [IW-1:0] state_idx,
    output logic          idx_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          dir,
    output logic          locked,
    output logic [7:0]    err_cnt
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [RW-1:0] LOCK_TGT = RW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_TGT = MW'(MISS_MAX);

    jd_state_e     r_state;
    logic [IW-1:0] r_prev;
    logic          r_idxValid;
    logic          r_illegal;
    logic          r_seqErr;
    logic          r_dir;
    logic          r_dirSet;
    logic          r_locked;
    logic [RW-1:0] r_run;
    logic [MW-1:0] r_miss;
    logic [7:0]    r_errCnt;

    logic          w_legal;
    logic [IW-1:0] w_idx;
    step_e         w_step;
    logic          w_reversal;
    logic          w_seqErr;
    logic          w_errEvent;
    logic [RW-1:0] w_newRun;
    logic [MW-1:0] w_newMiss;

    johnson_word_decode #(.N(N)) u_decode (
        .i_code  (code_in),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    // A reversal only counts as a sequence error once the direction is locked
    always_comb begin
        w_step     = classify_step(32'(w_idx), 32'(r_prev), 32'(2 * N));
        w_reversal = ((w_step == FWD) && !r_dir) || ((w_step == BWD) && r_dir);
        w_seqErr   = w_legal && (r_state != SEARCH) &&
                     ((w_step == BAD) || ((r_state == LOCKED) && w_reversal));
        w_errEvent = code_valid && (!w_legal || w_seqErr);
        w_newRun   = r_dirSet ? r_run + 1'b1 : RW'(1);
        w_newMiss  = r_miss + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= SEARCH;
            r_prev     <= '0;
            r_idxValid <= 1'b0;
            r_illegal  <= 1'b0;
            r_seqErr   <= 1'b0;
            r_dir      <= 1'b1;
            r_dirSet   <= 1'b0;
            r_locked   <= 1'b0;
            r_run      <= '0;
            r_miss     <= '0;
            r_errCnt   <= '0;
        end else begin
            r_idxValid <= 1'b0;
            r_illegal  <= 1'b0;
            r_seqErr   <= w_errEvent && w_legal;

            if (err_clr) begin
                r_errCnt <= w_errEvent ? 8'd1 : 8'd0;
            end else if (w_errEvent && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
            end

            if (code_valid && !w_legal) begin
                r_illegal <= 1'b1;
                if (r_state == ACQUIRE) begin
                    r_state  <= SEARCH;
                    r_run    <= '0;
                    r_dirSet <= 1'b0;
                end else if (r_state == LOCKED) begin
                    if (w_newMiss == MISS_TGT) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_miss   <= '0;
                    end else begin
                        r_miss <= w_newMiss;
                    end
                end
            end else if (code_valid) begin
                r_idxValid <= 1'b1;
                r_prev     <= w_idx;
                case (r_state)
                    SEARCH: begin
                        r_state  <= ACQUIRE;
                        r_run    <= '0;
                        r_dirSet <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (w_step == BAD) begin
                            r_run    <= '0;
                            r_dirSet <= 1'b0;
                        end else if (w_step != HOLD) begin
                            if (!r_dirSet || !w_reversal) begin
                                r_dir    <= (w_step == FWD);
                                r_dirSet <= 1'b1;
                                r_run    <= w_newRun;
                                if (w_newRun == LOCK_TGT) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                    r_miss   <= '0;
                                end
                            end else begin
                                r_run    <= '0;
                                r_dirSet <= 1'b0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!w_seqErr) begin
                            r_miss <= '0;
                        end else if (w_newMiss == MISS_TGT) begin
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                            r_miss   <= '0;
                        end else begin
                            r_miss <= w_newMiss;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign state_idx = r_prev;
    assign idx_valid = r_idxValid;
    assign illegal   = r_illegal;
    assign seq_err   = r_seqErr;
    assign dir       = r_dir;
    assign locked    = r_locked;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed scenarios plus a random
// walk, compared every cycle against a table-driven behavioural model.
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;
    localparam int M        = 2 * N;
    localparam int IW       = $clog2(M);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  code_in;
    logic          code_valid;
    logic          err_clr;
    logic [IW-1:0] state_idx;
    logic          idx_valid;
    logic          illegal;
    logic          seq_err;
    logic          dir;
    logic          locked;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] jw [M];

    int mState, mPrev, mIdxValid, mIllegal, mSeqErr, mDir, mLocked;
    int mErr, mRun, mMiss, mDirSet;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .err_clr    (err_clr),
        .state_idx  (state_idx),
        .idx_valid  (idx_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .dir        (dir),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Position of a word in the forward Johnson table, or -1 if absent
    function automatic int lookup(input logic [N-1:0] w);
        for (int i = 0; i < M; i++) begin
            if (jw[i] == w) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] randIllegal();
        logic [N-1:0] w;
        w = N'($urandom);
        while (lookup(w) >= 0) w = N'($urandom);
        return w;
    endfunction

    task automatic modelReset();
        mState = 0; mPrev = 0; mIdxValid = 0; mIllegal = 0; mSeqErr = 0;
        mDir = 1; mLocked = 0; mErr = 0; mRun = 0; mMiss = 0; mDirSet = 0;
    endtask

    // States: 0 = SEARCH, 1 = ACQUIRE, 2 = LOCKED
    task automatic modelStep(input logic [N-1:0] c, input bit v, input bit clr, input bit rn);
        int idx, d, ev;
        if (!rn) begin
            modelReset();
            return;
        end
        mIdxValid = 0; mIllegal = 0; mSeqErr = 0; ev = 0;
        if (v) begin
            idx = lookup(c);
            if (idx < 0) begin
                mIllegal = 1; ev = 1;
                if (mState == 1) begin
                    mState = 0; mRun = 0; mDirSet = 0;
                end else if (mState == 2) begin
                    mMiss++;
                    if (mMiss >= MISS_MAX) begin mState = 0; mMiss = 0; end
                end
            end else begin
                mIdxValid = 1;
                d = (idx - mPrev + M) % M;
                mPrev = idx;
                if (mState == 0) begin
                    mState = 1; mRun = 0; mDirSet = 0;
                end else if (mState == 1) begin
                    if (d != 0 && d != 1 && d != M - 1) begin
                        mSeqErr = 1; ev = 1; mRun = 0; mDirSet = 0;
                    end else if (d != 0) begin
                        if (!mDirSet || (d == 1) == (mDir == 1)) begin
                            mDir = (d == 1) ? 1 : 0;
                            mDirSet = 1;
                            mRun++;
                            if (mRun >= LOCK_CNT) begin mState = 2; mMiss = 0; end
                        end else begin
                            mRun = 0; mDirSet = 0;
                        end
                    end
                end else begin
                    if (d == 0 || (d == 1 && mDir == 1) || (d == M - 1 && mDir == 0)) begin
                        mMiss = 0;
                    end else begin
                        mSeqErr = 1; ev = 1; mMiss++;
                        if (mMiss >= MISS_MAX) begin mState = 0; mMiss = 0; end
                    end
                end
            end
        end
        mLocked = (mState == 2) ? 1 : 0;
        if (clr) mErr = ev;
        else if (ev && mErr < 255) mErr++;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("state_idx", 32'(state_idx), 32'(mPrev));
        checkVal("idx_valid", 32'(idx_valid), 32'(mIdxValid));
        checkVal("illegal",   32'(illegal),   32'(mIllegal));
        checkVal("seq_err",   32'(seq_err),   32'(mSeqErr));
        checkVal("dir",       32'(dir),       32'(mDir));
        checkVal("locked",    32'(locked),    32'(mLocked));
        checkVal("err_cnt",   32'(err_cnt),   32'(mErr));
    endtask

    task automatic applyStimulus(input logic [N-1:0] c, input bit v, input bit clr, input bit rn);
        code_in = c; code_valid = v; err_clr = clr; rst_n = rn;
        @(posedge clk);
        modelStep(c, v, clr, rn);
        #1;
        checkOutput();
    endtask

    task automatic feedIdx(input int i);
        applyStimulus(jw[i], 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int pos, wdir, r;
        bit clr;
        for (int i = 0; i < M; i++) begin
            if (i <= N) jw[i] = N'((1 << i) - 1);
            else        jw[i] = N'(((1 << N) - 1) << (i - N));
        end
        modelReset();
        code_in = '0; code_valid = 1'b0; err_clr = 1'b0; rst_n = 1'b0;
        #2;

        $display("[TB] reset");
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);

        $display("[TB] forward lock and wrap-around");
        for (int i = 0; i < M; i++) feedIdx(i);
        feedIdx(0);
        feedIdx(0);
        feedIdx(M - 1);
        feedIdx(0);

        $display("[TB] illegal words while locked");
        feedIdx(1);
        feedIdx(2);
        applyStimulus(4'b0101, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0101, 1'b1, 1'b0, 1'b1);
        feedIdx(3);

        $display("[TB] backward lock and acquire restarts");
        feedIdx(0); feedIdx(7); feedIdx(6); feedIdx(5);
        feedIdx(4); feedIdx(3);
        applyStimulus(4'b0110, 1'b1, 1'b0, 1'b1);
        feedIdx(3); feedIdx(4); feedIdx(3); feedIdx(0); feedIdx(1);
        for (int i = 0; i < 4; i++) applyStimulus(N'($urandom), 1'b0, 1'b0, 1'b1);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++) applyStimulus(randIllegal(), 1'b1, 1'b0, 1'b1);
        applyStimulus(randIllegal(), 1'b1, 1'b1, 1'b1);
        applyStimulus(randIllegal(), 1'b1, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b1, 1'b1);

        $display("[TB] random walk");
        pos = 0; wdir = 1;
        for (int i = 0; i < 500; i++) begin
            r   = $urandom_range(0, 99);
            clr = ($urandom_range(0, 24) == 0);
            if (r < 55) begin
                pos = (pos + (wdir ? 1 : M - 1)) % M;
                applyStimulus(jw[pos], 1'b1, clr, 1'b1);
            end else if (r < 65) begin
                applyStimulus(jw[pos], 1'b1, clr, 1'b1);
            end else if (r < 71) begin
                wdir = 1 - wdir;
                pos = (pos + (wdir ? 1 : M - 1)) % M;
                applyStimulus(jw[pos], 1'b1, clr, 1'b1);
            end else if (r < 79) begin
                pos = $urandom_range(0, M - 1);
                applyStimulus(jw[pos], 1'b1, clr, 1'b1);
            end else if (r < 87) begin
                applyStimulus(randIllegal(), 1'b1, clr, 1'b1);
            end else if (r < 97) begin
                applyStimulus(N'($urandom), 1'b0, clr, 1'b1);
            end else begin
                applyStimulus(jw[pos], 1'b1, clr, 1'b0);
            end
        end

        $display("[TB] reset mid-LOCKED");
        feedIdx(2); feedIdx(3); feedIdx(4); feedIdx(5);
        applyStimulus(randIllegal(), 1'b1, 1'b0, 1'b1);
        applyStimulus(jw[6], 1'b1, 1'b1, 1'b0);
        feedIdx(7);
        feedIdx(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's Johnson/ring counter. Samples an N-stage Johnson-coded bus and decodes each word to a binary state index. Checks that successive words follow the legal Johnson sequence in either direction, and reports direction, lock status and a saturating error count. Sits at the consumer of any counter-encoded phase/position bus, e.g. a phase selector or a rotary-position front end.

## Interface
- N, 4, number of Johnson stages; the code has 2N legal states; N ≥ 2
- LOCK_CNT, 3, consecutive same-direction steps required to lock; ≥ 1
- MISS_MAX, 2, consecutive errors tolerated in LOCKED before dropping to SEARCH; ≥ 1
- IW, $clog2(2*N), derived index width (localparam)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- code_in  in  N  Johnson-coded word
- code_valid  in  1  code_in is sampled only when high
- err_clr  in  1  clears err_cnt
- state_idx  out  IW  decoded index of the last legal word
- idx_valid  out  1  one-cycle pulse: state_idx updated
- illegal  out  1  one-cycle pulse: sampled word is not a Johnson word
- seq_err  out  1  one-cycle pulse: legal word, but not hold, successor or predecessor
- dir  out  1  1 = forward (index increasing), 0 = backward
- locked  out  1  FSM in LOCKED
- err_cnt  out  8  saturating count of illegal + seq_err events

## Operation
- Legal words have the form 0…01…1 or 1…10…0 (all-zero and all-one included). Forward order for N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Decode: p = popcount(code). idx = p if code[0]=1 or code=0; otherwise idx = 2N − p.
- Step classification against the previous index `prev` (mod 2N):
  - idx = prev: hold; no progress, not an error.
  - idx = prev+1: forward step.
  - idx = prev−1: backward step.
  - any other value: seq_err.
  - Wrap-around (7→0 forward, 0→7 backward for N=4) is a legal step.
- Behaviour on an illegal word: illegal pulses, `prev` and state_idx are unchanged, and idx_valid stays low.
- FSM states: SEARCH, ACQUIRE, LOCKED.
  - SEARCH: the first legal word sets `prev` and moves to ACQUIRE with run=0.
  - ACQUIRE: the first step sets dir. Each further step in dir increments run; when run reaches LOCK_CNT, move to LOCKED. An opposite-direction step or a seq_err restarts ACQUIRE using the new word as reference. An illegal word moves to SEARCH.
  - LOCKED: each illegal word, seq_err or direction reversal counts as a miss. Misses are counted as an error, and a reversal additionally asserts seq_err. A correct step or a hold clears miss. miss = MISS_MAX moves to SEARCH.
- err_cnt: increments by 1 per sampled word flagged illegal or seq_err, in any state. Saturates at 255. err_clr has priority to clear, but err_clr and an error in the same cycle give err_cnt = 1.
- code_valid low: no state change; all pulses low.

## Timing
- Registered outputs; 1-cycle latency. A word sampled at edge k is reflected on state_idx, idx_valid, illegal, seq_err, dir and locked after edge k, visible during cycle k+1.
- locked rises in the same cycle as the idx_valid pulse for the LOCK_CNT-th consistent step.
- Back-to-back code_valid is fully supported: one word per cycle, no stall.
- Reset values: state SEARCH, state_idx=0, idx_valid=0, illegal=0, seq_err=0, dir=1, locked=0, err_cnt=0, run=0, miss=0.
- rst_n low mid-operation overrides code_valid and err_clr in that cycle and discards any in-flight word.

## Structure
- Package johnson_pkg holds:
  - enum jd_state_e {SEARCH, ACQUIRE, LOCKED}
  - the step-class enum {HOLD, FWD, BWD, BAD}
- One combinational sub-module, johnson_word_decode (parameter N): code → legal, idx. It is reusable by other counter consumers.
- Top level holds the FSM, the run/miss counters, the prev register and err_cnt.

## Test plan
- Reset, then N=4 forward stream 0000,0001,0011,0111 every cycle → idx 0,1,2,3; locked=1 after the 4th word with dir=1; err_cnt=0.
- While locked forward, feed 1000 then 0000 → idx 7 then 0, no error (wrap-around); then 1000 → reversal: seq_err=1, miss=1, err_cnt=1.
- Inject 0101 while locked at idx 2 → illegal=1, state_idx stays 2; a second 0101 → SEARCH, locked=0, err_cnt=2.
- Backward stream 0000,1000,1100,1110 → idx 0,7,6,5; dir=0; locked after the 4th word.
- Drive err_cnt to 255 with 300 illegal words → stays 255; err_clr together with an illegal word → err_cnt=1.
- Assert rst_n=0 for one cycle mid-LOCKED with code_valid=1 → all outputs at reset values the next cycle, state SEARCH.
